// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI-over-APB sequencer: FSM states, SPI core register map, error codes.
package spi_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG0,
    CFG1,
    CFG2,
    WAIT_TX,
    WR_DR,
    POLL,
    RD_DR,
    PUSH,
    ERR
  } state_t;

  typedef struct packed {
    logic [7:0] cr1;
    logic [7:0] cr2;
    logic [7:0] br;
  } cfg_t;

  localparam logic [2:0] CR1_A = 3'd0;
  localparam logic [2:0] CR2_A = 3'd1;
  localparam logic [2:0] BR_A  = 3'd2;
  localparam logic [2:0] SR_A  = 3'd3;
  localparam logic [2:0] DR_A  = 3'd5;

  localparam int SPIF_BIT = 7;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SLVERR  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB access engine: SETUP in the cycle req rises, ACCESS next, done when PREADY is seen (2 cycles minimum).
// PREADY low stretches ACCESS; the requester must hold req/wr/addr/wdata until done.
module apb_master_xfer (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       req,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       slverr,
  output logic [2:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR
);

  logic access_q;

  // A completed access drops back to SETUP so back-to-back requests need no idle cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      access_q <= 1'b0;
    end else if (!req || (access_q && PREADY)) begin
      access_q <= 1'b0;
    end else begin
      access_q <= 1'b1;
    end
  end

  assign PSEL    = req;
  assign PENABLE = req & access_q;
  assign PWRITE  = wr;
  assign PADDR   = addr;
  assign PWDATA  = wdata;

  assign done   = req & access_q & PREADY;
  assign rdata  = PRDATA;
  assign slverr = done & PSLVERR;

endmodule

// File: rtl/spi_apb_sequencer.sv
// Streams bytes through an APB SPI core: program CR1/CR2/BR, then per byte write DR, poll SR.SPIF, read DR, return it.
// Byte latency 2+2*polls+2 cycles plus PREADY waits; rx_valid holds until rx_ready, tx is only taken between bytes.
module spi_apb_sequencer
  import spi_seq_pkg::*;
#(
  parameter int POLL_LIMIT = 4096,
  parameter int CNT_W      = $clog2(POLL_LIMIT + 1)
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_cr1,
  input  logic [7:0] cfg_cr2,
  input  logic [7:0] cfg_br,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_last,
  output logic [2:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  state_t           state, state_nxt;
  cfg_t             cfg_q;
  logic [7:0]       tx_data_q;
  logic             tx_last_q;
  logic             configured;
  logic [CNT_W-1:0] poll_cnt;

  logic       req, wr, done, slverr;
  logic [2:0] addr;
  logic [7:0] wdata, rdata;
  logic       cfg_hs, tx_hs, poll_last, timeout;

  apb_master_xfer u_xfer (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .req     (req),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .done    (done),
    .rdata   (rdata),
    .slverr  (slverr),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  assign cfg_hs    = cfg_valid & cfg_ready;
  assign tx_hs     = tx_valid & tx_ready;
  assign poll_last = (poll_cnt == CNT_W'(POLL_LIMIT - 1));
  assign timeout   = (state == POLL) && done && !slverr && !rdata[SPIF_BIT] && poll_last;
  assign busy      = (state != IDLE);
  assign rx_last   = tx_last_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    wr        = 1'b0;
    addr      = CR1_A;
    wdata     = 8'h00;
    cfg_ready = 1'b0;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        tx_ready  = configured && !cfg_valid;
        if (cfg_valid)                state_nxt = CFG0;
        else if (tx_valid && tx_ready) state_nxt = WR_DR;
      end
      CFG0: begin
        req = 1'b1; wr = 1'b1; addr = CR1_A; wdata = cfg_q.cr1;
        if (done) state_nxt = CFG1;
      end
      CFG1: begin
        req = 1'b1; wr = 1'b1; addr = CR2_A; wdata = cfg_q.cr2;
        if (done) state_nxt = CFG2;
      end
      CFG2: begin
        req = 1'b1; wr = 1'b1; addr = BR_A; wdata = cfg_q.br;
        if (done) state_nxt = IDLE;
      end
      // Mid-burst: a pending cfg_valid stalls the stream rather than being accepted.
      WAIT_TX: begin
        tx_ready = configured && !cfg_valid;
        if (tx_valid && tx_ready) state_nxt = WR_DR;
      end
      WR_DR: begin
        req = 1'b1; wr = 1'b1; addr = DR_A; wdata = tx_data_q;
        if (done) state_nxt = POLL;
      end
      POLL: begin
        req = 1'b1; addr = SR_A;
        if (done) begin
          if (rdata[SPIF_BIT]) state_nxt = RD_DR;
          else if (poll_last)  state_nxt = ERR;
        end
      end
      RD_DR: begin
        req = 1'b1; addr = DR_A;
        if (done) state_nxt = PUSH;
      end
      PUSH: begin
        rx_valid = 1'b1;
        if (rx_ready) state_nxt = tx_last_q ? IDLE : WAIT_TX;
      end
      ERR: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_nxt = CFG0;
      end
      default: state_nxt = IDLE;
    endcase
    if (slverr) state_nxt = ERR;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cfg_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_last_q  <= 1'b0;
      configured <= 1'b0;
      poll_cnt   <= '0;
      rx_data    <= 8'h00;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      if (cfg_hs) begin
        cfg_q    <= '{cr1: cfg_cr1, cr2: cfg_cr2, br: cfg_br};
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
      if (tx_hs) begin
        tx_data_q <= tx_data;
        tx_last_q <= tx_last;
      end
      if ((state == CFG2) && done && !slverr) configured <= 1'b1;
      if (state == WR_DR)                poll_cnt <= '0;
      else if ((state == POLL) && done)  poll_cnt <= poll_cnt + CNT_W'(1);
      if ((state == RD_DR) && done && !slverr) rx_data <= rdata;
      if (slverr) begin
        err        <= 1'b1;
        err_code   <= ERR_SLVERR;
        configured <= 1'b0;
      end else if (timeout) begin
        err        <= 1'b1;
        err_code   <= ERR_TIMEOUT;
        configured <= 1'b0;
      end
    end
  end

endmodule
